// File: rtl/resize_src_pixel_responder.sv
// Source-pixel responder for the resize engine: converts Q.FIXED request coordinates
// into a clamped frame-buffer address, fetches the pixel and returns it with its weights.
module resize_src_pixel_responder #(
  parameter int FIXED   = 11,
  parameter int COORD_W = 22,
  parameter int PIX_W   = 8,
  parameter int DIM_W   = 11,
  parameter int ADDR_W  = 22,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIM_W-1:0]   src_width,
  input  logic [DIM_W-1:0]   src_height,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  input  logic               req_last,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [PIX_W-1:0]   mem_rd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [PIX_W-1:0]   rsp_pix,
  output logic [FIXED-1:0]   rsp_frac_x,
  output logic [FIXED-1:0]   rsp_frac_y,
  output logic               rsp_last,
  output logic               busy,
  output logic               done,
  output logic               err_oob
);

  localparam int INT_W  = COORD_W - FIXED;
  localparam int CMP_W  = (INT_W > DIM_W) ? INT_W : DIM_W;
  localparam int PROD_W = 2 * DIM_W;
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DIM_W-1:0]  width_q, height_q;
  logic [CNT_W-1:0]  cnt;
  logic [DIM_W-1:0]  ix_p0, iy_p0;
  logic [FIXED-1:0]  fx_p0, fy_p0;
  logic              last_p0;
  logic [PIX_W-1:0]  pix_p1;
  logic [PROD_W-1:0] addr_full;
  logic              acc, over_x, over_y, cap;

  function automatic logic exceeds(input logic [INT_W-1:0] c, input logic [DIM_W-1:0] lim);
    return CMP_W'(c) >= CMP_W'(lim);
  endfunction

  // Saturate an integer coordinate to the last valid pixel of the latched dimension.
  function automatic logic [DIM_W-1:0] clamp_coord(input logic [INT_W-1:0] c,
                                                   input logic [DIM_W-1:0] lim);
    if (exceeds(c, lim)) return lim - DIM_W'(1);
    return DIM_W'(c);
  endfunction

  assign acc    = (state == S_READY) && req_valid;
  assign over_x = exceeds(req_x[COORD_W-1:FIXED], width_q);
  assign over_y = exceeds(req_y[COORD_W-1:FIXED], height_q);
  assign cap    = (state == S_WAIT) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    rsp_valid = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_READY;
      end
      S_READY: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mem_rd_en = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CNT_LAST) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = last_p0 ? S_DONE : S_READY;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q  <= '0;
      height_q <= '0;
      cnt      <= '0;
      err_oob  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        width_q  <= src_width;
        height_q <= src_height;
        err_oob  <= 1'b0;
      end else if (acc && (over_x || over_y)) begin
        err_oob <= 1'b1;
      end
      if (state == S_ISSUE)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + CNT_W'(1);
    end
  end

  // p0: accepted request, clamped before the address multiply
  always_ff @(posedge clk) begin
    if (acc) begin
      ix_p0   <= clamp_coord(req_x[COORD_W-1:FIXED], width_q);
      iy_p0   <= clamp_coord(req_y[COORD_W-1:FIXED], height_q);
      fx_p0   <= over_x ? '0 : req_x[FIXED-1:0];
      fy_p0   <= over_y ? '0 : req_y[FIXED-1:0];
      last_p0 <= req_last;
    end
  end

  // p1: pixel captured MEM_LAT cycles after the read strobe
  always_ff @(posedge clk) begin
    if (cap) pix_p1 <= mem_rd_data;
  end

  assign addr_full   = PROD_W'(iy_p0) * PROD_W'(width_q) + PROD_W'(ix_p0);
  assign mem_rd_addr = mem_rd_en ? ADDR_W'(addr_full) : '0;

  // Data registers carry no reset, so outputs are qualified by their strobes.
  assign rsp_pix    = rsp_valid ? pix_p1  : '0;
  assign rsp_frac_x = rsp_valid ? fx_p0   : '0;
  assign rsp_frac_y = rsp_valid ? fy_p0   : '0;
  assign rsp_last   = rsp_valid ? last_p0 : 1'b0;

endmodule

// File: tb/tb_resize_src_pixel_responder.sv
// Bench for resize_src_pixel_responder: table vectors, hand-written corner sequences and
// randomized frames checked against a plain-arithmetic coordinate/memory model.
module tb_resize_src_pixel_responder;
  localparam int FIXED   = 11;
  localparam int COORD_W = 22;
  localparam int PIX_W   = 8;
  localparam int DIM_W   = 11;
  localparam int ADDR_W  = 22;
  localparam int MEM_LAT = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [DIM_W-1:0]   src_width = '0;
  logic [DIM_W-1:0]   src_height = '0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [COORD_W-1:0] req_x = '0;
  logic [COORD_W-1:0] req_y = '0;
  logic               req_last = 1'b0;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic [PIX_W-1:0]   mem_rd_data;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [PIX_W-1:0]   rsp_pix;
  logic [FIXED-1:0]   rsp_frac_x;
  logic [FIXED-1:0]   rsp_frac_y;
  logic               rsp_last;
  logic               busy;
  logic               done;
  logic               err_oob;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [PIX_W-1:0] key = 8'h00;

  resize_src_pixel_responder #(
    .FIXED(FIXED), .COORD_W(COORD_W), .PIX_W(PIX_W),
    .DIM_W(DIM_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_width(src_width), .src_height(src_height),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .req_last(req_last), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_pix(rsp_pix), .rsp_frac_x(rsp_frac_x), .rsp_frac_y(rsp_frac_y),
    .rsp_last(rsp_last), .busy(busy), .done(done), .err_oob(err_oob)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: pixel at address a is a[7:0]^key, delivered MEM_LAT cycles after the strobe.
  logic [MEM_LAT-1:0] mvld;
  logic [ADDR_W-1:0]  maddr [MEM_LAT];
  always @(posedge clk) begin
    mvld[0]  <= mem_rd_en;
    maddr[0] <= mem_rd_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      mvld[i]  <= mvld[i-1];
      maddr[i] <= maddr[i-1];
    end
  end
  assign mem_rd_data = mvld[MEM_LAT-1] ? (maddr[MEM_LAT-1][PIX_W-1:0] ^ key) : PIX_W'(8'hEE);

  function automatic logic [PIX_W-1:0] pix_of(input int a);
    return PIX_W'(a) ^ key;
  endfunction

  function automatic void model(input int x, input int y, input int w, input int h,
                                output int addr, output int fx, output int fy, output bit oob);
    int ix, iy;
    ix  = x / (1 << FIXED);
    iy  = y / (1 << FIXED);
    fx  = x % (1 << FIXED);
    fy  = y % (1 << FIXED);
    oob = 1'b0;
    if (ix >= w) begin ix = w - 1; fx = 0; oob = 1'b1; end
    if (iy >= h) begin iy = h - 1; fy = 0; oob = 1'b1; end
    addr = iy * w + ix;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic start_frame(input int w, input int h);
    src_width  = DIM_W'(w);
    src_height = DIM_W'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src_width  = DIM_W'($urandom);
    src_height = DIM_W'($urandom);
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_req_ready", 64'(req_ready), 64'(1));
    chk("start_oob_clear", 64'(err_oob), 64'(0));
  endtask

  // hold<0: rsp_ready held high throughout; stray pulses start during the hold window.
  task automatic do_req(input int x, input int y, input bit last, input int hold, input bit stray,
                        input int ea, input int efx, input int efy, input bit eo,
                        inout bit oob_acc, output int rsp_cyc);
    int n, rd_cnt;
    bit stable;
    logic [PIX_W-1:0] ep;
    oob_acc   = oob_acc | eo;
    ep        = pix_of(ea);
    rsp_ready = (hold < 0);
    req_x     = COORD_W'(x);
    req_y     = COORD_W'(y);
    req_last  = last;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_accept_bound", 64'(n < 20), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_x     = COORD_W'($urandom);
    req_y     = COORD_W'($urandom);
    req_last  = 1'($urandom);
    chk("rd_en", 64'(mem_rd_en), 64'(1));
    chk("rd_addr", 64'(mem_rd_addr), 64'(ea));
    chk("req_ready_low", 64'(req_ready), 64'(0));
    n = 1;
    rd_cnt = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
      if (mem_rd_en) rd_cnt++;
    end
    rsp_cyc = cyc;
    chk("rsp_latency", 64'(n), 64'(MEM_LAT + 2));
    chk("rd_en_single", 64'(rd_cnt), 64'(0));
    chk("rsp_pix", 64'(rsp_pix), 64'(ep));
    chk("rsp_frac_x", 64'(rsp_frac_x), 64'(efx));
    chk("rsp_frac_y", 64'(rsp_frac_y), 64'(efy));
    chk("rsp_last", 64'(rsp_last), 64'(last));
    chk("err_oob", 64'(err_oob), 64'(oob_acc));
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (stray && i == 0) begin
        start = 1'b1; src_width = 11'd100; src_height = 11'd50;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (rsp_valid !== 1'b1 || rsp_pix !== ep || rsp_frac_x !== FIXED'(efx) ||
          rsp_frac_y !== FIXED'(efy) || req_ready !== 1'b0 || err_oob !== oob_acc)
        stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 64'(stable), 64'(1));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = (hold < 0);
    chk("rsp_released", 64'(rsp_valid), 64'(0));
    if (last) begin
      chk("done_pulse", 64'(done), 64'(1));
      chk("busy_in_done", 64'(busy), 64'(1));
      @(posedge clk); #1;
      chk("done_clear", 64'(done), 64'(0));
      chk("busy_fall", 64'(busy), 64'(0));
    end else begin
      chk("ready_again", 64'(req_ready), 64'(1));
    end
  endtask

  typedef struct {
    int x, y, w, h;
    int addr, fx, fy;
    bit oob;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ea, efx, efy, c;
    int sp [4];
    bit eo, o, quiet;

    tbl[0] = '{'h0C00, 'h0800, 640, 480, 641, 'h400, 0, 1'b0};
    tbl[1] = '{700 * 2048, 2 * 2048 + 5, 640, 480, 1919, 0, 5, 1'b1};
    tbl[2] = '{10 * 2048 + 'h7FF, 479 * 2048 + 3, 640, 480, 306570, 'h7FF, 3, 1'b0};
    tbl[3] = '{5 * 2048 + 1, 480 * 2048 + 9, 640, 480, 306565, 1, 0, 1'b1};
    tbl[4] = '{'h3FFFFF, 'h3FFFFF, 640, 480, 307199, 0, 0, 1'b1};
    tbl[5] = '{0, 0, 640, 480, 0, 0, 0, 1'b0};
    tbl[6] = '{3 * 2048 + 4, 'h10, 1, 1, 0, 0, 'h10, 1'b1};
    tbl[7] = '{2046 * 2048 + 1, 2046 * 2048 + 2, 2047, 2047, 4190208, 1, 2, 1'b0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_pix, rsp_frac_x,
                              rsp_frac_y, rsp_last, busy, done, err_oob}), 64'(0));
    rst_n = 1'b1;

    // Request while idle stays pending
    req_valid = 1'b1;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (req_ready || mem_rd_en || busy) quiet = 1'b0;
    end
    chk("idle_req_ignored", 64'(quiet), 64'(1));
    req_valid = 1'b0;

    // Basic fetch with 5-cycle backpressure; memory returns 0xA5 at address 641
    key = 8'h24;
    o = 1'b0;
    start_frame(640, 480);
    chk("pix_key_a5", 64'(pix_of(641)), 64'(8'hA5));
    do_req('h0C00, 'h0800, 1'b0, 5, 1'b0, 641, 'h400, 0, 1'b0, o, c);
    do_req(0, 0, 1'b1, 0, 1'b0, 0, 0, 0, 1'b0, o, c);

    // Clamped x sets sticky err_oob; next start clears it
    key = 8'h5A;
    o = 1'b0;
    start_frame(640, 480);
    do_req(700 * 2048, 3 * 2048 + 7, 1'b0, 0, 1'b0, 3 * 640 + 639, 0, 7, 1'b1, o, c);
    do_req(5 * 2048, 5 * 2048, 1'b1, 1, 1'b0, 5 * 640 + 5, 0, 0, 1'b0, o, c);

    // Table vectors, one single-request frame each
    for (int i = 0; i < 8; i++) begin
      key = 8'(i * 37 + 11);
      o = 1'b0;
      start_frame(tbl[i].w, tbl[i].h);
      do_req(tbl[i].x, tbl[i].y, 1'b1, i % 3, 1'b0, tbl[i].addr, tbl[i].fx, tbl[i].fy,
             tbl[i].oob, o, c);
    end

    // Streaming: four requests with rsp_ready held high, one pixel per MEM_LAT+3 cycles
    key = 8'h99;
    o = 1'b0;
    start_frame(640, 480);
    for (int i = 0; i < 4; i++) begin
      model(i * 3000 + 100, i * 5000 + 7, 640, 480, ea, efx, efy, eo);
      do_req(i * 3000 + 100, i * 5000 + 7, i == 3, -1, 1'b0, ea, efx, efy, eo, o, sp[i]);
    end
    for (int i = 1; i < 4; i++) chk("stream_spacing", 64'(sp[i] - sp[i-1]), 64'(MEM_LAT + 3));
    rsp_ready = 1'b0;

    // Start pulsed during the hold window is ignored
    key = 8'h17;
    o = 1'b0;
    start_frame(640, 480);
    do_req(700 * 2048, 1 * 2048, 1'b0, 3, 1'b1, 1 * 640 + 639, 0, 0, 1'b1, o, c);
    do_req(3 * 2048, 2 * 2048, 1'b1, 0, 1'b0, 2 * 640 + 3, 0, 0, 1'b0, o, c);

    // Reset asserted while the read is in flight
    key = 8'h3C;
    start_frame(640, 480);
    req_x = COORD_W'(700 * 2048); req_y = '0; req_last = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t5_issue", 64'(mem_rd_en), 64'(1));
    @(posedge clk); #1;
    chk("t5_oob_before_reset", 64'(err_oob), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", 64'({req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_pix, rsp_frac_x,
                                  rsp_frac_y, rsp_last, busy, done, err_oob}), 64'(0));
    #2 rst_n = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid || busy || mem_rd_en || done || req_ready) quiet = 1'b0;
    end
    chk("late_data_ignored", 64'(quiet), 64'(1));
    o = 1'b0;
    start_frame(320, 240);
    model(12 * 2048 + 9, 200 * 2048 + 1, 320, 240, ea, efx, efy, eo);
    do_req(12 * 2048 + 9, 200 * 2048 + 1, 1'b1, 2, 1'b0, ea, efx, efy, eo, o, c);

    // Randomized frames against the model
    for (int f = 0; f < 8; f++) begin
      int w, h, nreq, ix, iy, x, y, hold;
      w = int'($urandom_range(1, 2047));
      h = int'($urandom_range(1, 2047));
      nreq = int'($urandom_range(1, 5));
      key = 8'($urandom);
      o = 1'b0;
      start_frame(w, h);
      for (int r = 0; r < nreq; r++) begin
        ix = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, w - 1));
        iy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, h - 1));
        x = ix * 2048 + int'($urandom_range(0, 2047));
        y = iy * 2048 + int'($urandom_range(0, 2047));
        hold = int'($urandom_range(0, 4)) - 1;
        model(x, y, w, h, ea, efx, efy, eo);
        do_req(x, y, r == nreq - 1, hold, 1'b0, ea, efx, efy, eo, o, c);
      end
      rsp_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
